iob_sp_ram_be_arb: RTL and testbench
====================================

IOB_SP_RAM_BE_ARB -- requirements
Module: iob_sp_ram_be_arb

Interface
REQ-001 The module SHALL have parameter NUM_COL, default 2, the number of byte-enable columns.
REQ-002 The module SHALL have parameter COL_WIDTH, default 4, the bits per column.
REQ-003 The module SHALL have parameter DATA_WIDTH, default NUM_COL*COL_WIDTH, the RAM word width.
REQ-004 The module SHALL have parameter ADDR_WIDTH, default 4, the RAM address width.
REQ-005 The module SHALL have one clock and a synchronous, active-high reset: clk  input  1  clock; rst  input  1  reset.
REQ-006 The module SHALL have a_req  input  1  requester A access request, held until a_ack.
REQ-007 The module SHALL have a_we  input  NUM_COL  requester A column write enables; all zero means read.
REQ-008 The module SHALL have a_addr  input  ADDR_WIDTH  requester A address.
REQ-009 The module SHALL have a_wdata  input  DATA_WIDTH  requester A write data.
REQ-010 The module SHALL have a_ack  output  1  requester A request accepted this cycle.
REQ-011 The module SHALL have a_rvalid  output  1  requester A read data valid.
REQ-012 The module SHALL have a_rdata  output  DATA_WIDTH  requester A read data.
REQ-013 The module SHALL have ports b_req, b_we, b_addr, b_wdata, b_ack, b_rvalid and b_rdata for requester B, identical in direction, width and meaning to the requester A ports.
REQ-014 The module SHALL have the RAM-side ports: ram_en  output  1; ram_we  output  NUM_COL; ram_addr  output  ADDR_WIDTH; ram_din  output  DATA_WIDTH; ram_dout  input  DATA_WIDTH (1-cycle read latency).

Function
REQ-015 The arbiter SHALL grant at most one requester per cycle; x_ack SHALL be combinational: high in the same cycle x_req is high and x is granted.
REQ-016 On grant in cycle T, the arbiter SHALL register ram_en=1, ram_we=x_we, ram_addr=x_addr and ram_din=x_wdata, so that they are visible to the RAM in cycle T+1.
REQ-017 With no grant in cycle T, the arbiter SHALL drive ram_en=0 and ram_we=0 in cycle T+1; ram_addr and ram_din SHALL hold their previous values.
REQ-018 For a granted read (x_we==0) in cycle T, x_rvalid SHALL be high for exactly one cycle, T+2, with x_rdata=ram_dout.
REQ-019 A granted write SHALL produce no rvalid pulse; partial x_we SHALL be passed through unchanged.
REQ-020 Throughput SHALL be one grant per cycle; back-to-back grants SHALL be supported with no bubble.
REQ-021 A 2-deep owner/read tag pipeline SHALL route each rvalid pulse only to the requester that issued the read.
REQ-022 When both requesters request in the same cycle, the winner SHALL be selected by the policy given in REQ-029/REQ-030; the loser SHALL see x_ack=0 and SHALL keep its request pending.
REQ-023 x_rdata SHALL equal ram_dout at all times and SHALL be meaningful only when x_rvalid is high.

Reset
REQ-024 While rst is high at a clk edge, the module SHALL clear ram_en and ram_we to 0 and ram_addr and ram_din to 0.
REQ-025 While rst is high at a clk edge, the module SHALL clear both tag stages (so that a_rvalid=b_rvalid=0) and point the priority pointer at A.
REQ-026 While rst is high, the module SHALL drive a_ack=b_ack=0.
REQ-027 Reset asserted mid-operation SHALL discard in-flight reads; no rvalid pulse SHALL appear after reset for those reads.

Configuration
REQ-028 The module SHALL compile the arbitration policy under macro IOB_SP_RAM_ARB_RR_EN.
REQ-029 With IOB_SP_RAM_ARB_RR_EN defined, arbitration SHALL be round-robin: on a conflict the requester not granted most recently wins; the pointer SHALL update only on a grant.
REQ-030 With IOB_SP_RAM_ARB_RR_EN undefined, arbitration SHALL be fixed priority with A always winning over B, and no pointer state.

Verification
REQ-031 Single read: RAM preloaded with 0x5A at address 3; a_req=1, a_we=0, a_addr=3 in cycle T -> a_ack=1 in T, a_rvalid=1 and a_rdata=0x5A in T+2, b_rvalid=0 throughout.
REQ-032 Partial write: b_we=2'b01, b_addr=7, b_wdata=0xF3 onto a stored 0xA0 -> no rvalid pulse; a following read of address 7 returns 0xA3.
REQ-033 Conflict: a_req and b_req held high for 4 cycles -> with RR_EN the ack sequence is A,B,A,B; without it the sequence is A,A,A,A and b_ack stays 0.
REQ-034 Streaming: A reads addresses 0..15 on consecutive cycles -> 16 acks in 16 cycles, 16 rvalid pulses whose data matches the preload in order.
REQ-035 Reset mid-read: rst high in T+1 after a read grant in T -> no rvalid in T+2, and ram_en=0 after reset.

Source files
------------

// File: rtl/iob_sp_ram_be_arb.sv
// iob_sp_ram_be_arb: two-requester arbiter in front of a
// single-port byte-enable RAM with 1-cycle read latency.
//
// Policy macro: IOB_SP_RAM_ARB_RR_EN
//   defined   -> round-robin (requester not granted last wins)
//   undefined -> fixed priority, A always beats B
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   a_req/a_we/a_addr   requester A request, column WEs, address
//   a_wdata             requester A write data
//   a_ack               A granted this cycle (combinational)
//   a_rvalid/a_rdata    A read response, two cycles after grant
//   b_*                 same set for requester B
//   ram_en/ram_we       registered RAM enable / column WEs
//   ram_addr/ram_din    registered RAM address / write data
//   ram_dout            RAM read data
module iob_sp_ram_be_arb #(
  parameter int NUM_COL    = 2,
  parameter int COL_WIDTH  = 4,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic [NUM_COL-1:0]    a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic [NUM_COL-1:0]    b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_en,
  output logic [NUM_COL-1:0]    ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  logic a_gnt;
  logic b_gnt;

`ifdef IOB_SP_RAM_ARB_RR_EN
  // prio_a set: A wins the next conflict
  logic prio_a;

  assign a_gnt = !rst && a_req &&
                 (!b_req || prio_a);
  assign b_gnt = !rst && b_req &&
                 (!a_req || !prio_a);

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_a <= 1'b1;
    end else if (a_gnt) begin
      prio_a <= 1'b0;
    end else if (b_gnt) begin
      prio_a <= 1'b1;
    end
  end
`else
  assign a_gnt = !rst && a_req;
  assign b_gnt = !rst && b_req && !a_req;
`endif

  assign a_ack = a_gnt;
  assign b_ack = b_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en   <= 1'b0;
      ram_we   <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      unique case (1'b1)
        a_gnt: begin
          ram_en   <= 1'b1;
          ram_we   <= a_we;
          ram_addr <= a_addr;
          ram_din  <= a_wdata;
        end
        b_gnt: begin
          ram_en   <= 1'b1;
          ram_we   <= b_we;
          ram_addr <= b_addr;
          ram_din  <= b_wdata;
        end
        default: begin
          ram_en <= 1'b0;
          ram_we <= '0;
        end
      endcase
    end
  end

  // Tag pipeline: stage 1 matches the RAM command,
  // stage 2 matches the RAM data coming back.
  logic s1_vld;
  logic s1_b;
  logic s2_vld;
  logic s2_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_b   <= 1'b0;
      s2_vld <= 1'b0;
      s2_b   <= 1'b0;
    end else begin
      s1_vld <= (a_gnt && (a_we == '0)) ||
                (b_gnt && (b_we == '0));
      s1_b   <= b_gnt;
      s2_vld <= s1_vld;
      s2_b   <= s1_b;
    end
  end

  assign a_rvalid = s2_vld && !s2_b;
  assign b_rvalid = s2_vld && s2_b;
  assign a_rdata  = ram_dout;
  assign b_rdata  = ram_dout;

endmodule

// File: tb/tb_iob_sp_ram_be_arb.sv
// tb_iob_sp_ram_be_arb: directed bench for iob_sp_ram_be_arb
// with a byte-enable RAM model behind the arbiter.
module tb_iob_sp_ram_be_arb;

  localparam int NC = 2;
  localparam int CW = 4;
  localparam int DW = NC * CW;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, b_req;
  logic [NC-1:0] a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, b_ack;
  logic          a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_en;
  logic [NC-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] exp_mem [16];

  always #5 clk = ~clk;

  iob_sp_ram_be_arb #(
    .NUM_COL(NC), .COL_WIDTH(CW),
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_ack(a_ack),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_ack(b_ack),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // RAM model: column writes, 1-cycle registered read
  always @(posedge clk) begin
    if (ram_en) begin
      for (int c = 0; c < NC; c++)
        if (ram_we[c])
          mem[ram_addr][c*CW +: CW] <= ram_din[c*CW +: CW];
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    a_req = 0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = '0; b_addr = '0; b_wdata = '0;
  endtask

  logic [1:0] exp_ack [6];
  logic [1:0] exp_rv  [6];
  int acks, rvs;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = DW'((i << 4) | (15 - i));
      exp_mem[i] = mem[i];
    end
    mem[3] = 8'h5A; exp_mem[3] = 8'h5A;
    mem[7] = 8'hA0; exp_mem[7] = 8'hA0;
    ram_dout = '0;
    idle();
    rst = 1;

    // reset with both requests raised
    next_cycle();
    a_req = 1; b_req = 1;
    @(negedge clk);
    check("rst_a_ack", 32'(a_ack), 0);
    check("rst_b_ack", 32'(b_ack), 0);
    next_cycle();
    idle();
    @(negedge clk);
    check("rst_ram_en", 32'(ram_en), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_din", 32'(ram_din), 0);
    check("rst_a_rvalid", 32'(a_rvalid), 0);
    check("rst_b_rvalid", 32'(b_rvalid), 0);

    // single read of address 3
    next_cycle();
    rst = 0;
    a_req = 1; a_addr = 4'd3;
    @(negedge clk);
    check("rd_a_ack", 32'(a_ack), 1);
    check("rd_b_ack", 32'(b_ack), 0);
    next_cycle();
    idle();
    @(negedge clk);
    check("rd_ram_en", 32'(ram_en), 1);
    check("rd_ram_addr", 32'(ram_addr), 3);
    check("rd_ram_we", 32'(ram_we), 0);
    check("rd_early_rv", 32'(a_rvalid), 0);
    next_cycle();
    @(negedge clk);
    check("rd_a_rvalid", 32'(a_rvalid), 1);
    check("rd_a_rdata", 32'(a_rdata), 32'h5A);
    check("rd_b_rvalid", 32'(b_rvalid), 0);
    check("rd_ram_en_off", 32'(ram_en), 0);
    check("rd_addr_hold", 32'(ram_addr), 3);
    next_cycle();
    @(negedge clk);
    check("rd_rv_once", 32'(a_rvalid), 0);

    // partial write by B: low column only
    next_cycle();
    b_req = 1; b_we = 2'b01;
    b_addr = 4'd7; b_wdata = 8'hF3;
    @(negedge clk);
    check("wr_b_ack", 32'(b_ack), 1);
    next_cycle();
    idle();
    @(negedge clk);
    check("wr_ram_we", 32'(ram_we), 32'b01);
    check("wr_ram_din", 32'(ram_din), 32'hF3);
    exp_mem[7] = 8'hA3;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      @(negedge clk);
      check("wr_no_arv", 32'(a_rvalid), 0);
      check("wr_no_brv", 32'(b_rvalid), 0);
    end

    // read back address 7
    next_cycle();
    a_req = 1; a_addr = 4'd7;
    @(negedge clk);
    check("rb_a_ack", 32'(a_ack), 1);
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    check("rb_a_rvalid", 32'(a_rvalid), 1);
    check("rb_a_rdata", 32'(a_rdata), 32'hA3);

    // streaming reads 0..15, no bubbles
    acks = 0; rvs = 0;
    for (int i = 0; i < 18; i++) begin
      next_cycle();
      idle();
      if (i < 16) begin
        a_req = 1; a_addr = AW'(i);
      end
      @(negedge clk);
      if (a_ack) acks++;
      if (i >= 2) begin
        check("st_rvalid", 32'(a_rvalid), 1);
        check("st_rdata", 32'(a_rdata),
              32'(exp_mem[i-2]));
        if (a_rvalid) rvs++;
      end
    end
    check("st_acks", 32'(acks), 16);
    check("st_rvs", 32'(rvs), 16);
    next_cycle();
    @(negedge clk);
    check("st_rv_end", 32'(a_rvalid), 0);

    // reset one cycle after a read grant
    next_cycle();
    a_req = 1; a_addr = 4'd5;
    @(negedge clk);
    check("mr_a_ack", 32'(a_ack), 1);
    next_cycle();
    idle();
    rst = 1;
    @(negedge clk);
    check("mr_ack_rst", 32'(a_ack), 0);
    next_cycle();
    rst = 0;
    @(negedge clk);
    check("mr_no_rv", 32'(a_rvalid), 0);
    check("mr_ram_en", 32'(ram_en), 0);
    next_cycle();
    @(negedge clk);
    check("mr_no_rv2", 32'(a_rvalid), 0);

    // conflict: both request for four cycles
`ifdef IOB_SP_RAM_ARB_RR_EN
    exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10,
                2'b00, 2'b00};
    exp_rv  = '{2'b00, 2'b00, 2'b01, 2'b10,
                2'b01, 2'b10};
`else
    exp_ack = '{2'b01, 2'b01, 2'b01, 2'b01,
                2'b00, 2'b00};
    exp_rv  = '{2'b00, 2'b00, 2'b01, 2'b01,
                2'b01, 2'b01};
`endif
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      idle();
      if (i < 4) begin
        a_req = 1; a_addr = 4'd1;
        b_req = 1; b_addr = 4'd2;
      end
      @(negedge clk);
      check("cf_ack", 32'({b_ack, a_ack}),
            32'(exp_ack[i]));
      check("cf_rv", 32'({b_rvalid, a_rvalid}),
            32'(exp_rv[i]));
      if (exp_rv[i][0])
        check("cf_a_rdata", 32'(a_rdata),
              32'(exp_mem[1]));
      if (exp_rv[i][1])
        check("cf_b_rdata", 32'(b_rdata),
              32'(exp_mem[2]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
